// File: rtl/puf_eval_ctrl.sv
// Challenge-side controller for an arbiter/DAPUF: drives a challenge, fires the excitation
// lines REPEAT times, and returns a majority-voted response with a ones-count.
module puf_eval_ctrl #(
    parameter int unsigned CHAL_W     = 40,
    parameter int unsigned SETUP_CYC  = 4,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned REPEAT     = 5,
    parameter int unsigned CNT_W      = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              chal_valid_i,
    output logic              chal_ready_o,
    input  logic [CHAL_W-1:0] chal_data_i,
    output logic [CHAL_W-1:0] puf_challenge_o,
    output logic              puf_excite_l_o,
    output logic              puf_excite_r_o,
    input  logic              puf_response_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic              resp_bit_o,
    output logic [CNT_W-1:0]  resp_ones_o,
    output logic              resp_stable_o,
    output logic              busy_o
);

    localparam int unsigned PhMax = (SETUP_CYC > SETTLE_CYC) ? SETUP_CYC : SETTLE_CYC;
    localparam int unsigned PhW   = (PhMax > 1) ? $clog2(PhMax) : 1;

    localparam logic [PhW-1:0]   SetupLast  = PhW'(SETUP_CYC - 1);
    localparam logic [PhW-1:0]   SettleLast = PhW'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] EvalLast   = CNT_W'(REPEAT - 1);
    localparam logic [CNT_W-1:0] HalfRep    = CNT_W'(REPEAT / 2);
    localparam logic [CNT_W-1:0] AllOnes    = CNT_W'(REPEAT);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLow  = 2'd1;
    localparam logic [1:0] StHigh = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [PhW-1:0]    phase_q, phase_d;
    logic [CNT_W-1:0]  eval_q, eval_d;
    logic [CNT_W-1:0]  ones_q, ones_d;
    logic [CNT_W-1:0]  ones_sum;
    logic [CHAL_W-1:0] chal_q, chal_d;
    logic              excite_q, excite_d;
    logic              sync1_q, sync2_q;
    logic              rbit_q, rbit_d;
    logic [CNT_W-1:0]  rones_q, rones_d;
    logic              rstable_q, rstable_d;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        eval_d    = eval_q;
        ones_d    = ones_q;
        chal_d    = chal_q;
        rbit_d    = rbit_q;
        rones_d   = rones_q;
        rstable_d = rstable_q;
        ones_sum  = ones_q + CNT_W'(sync2_q);

        unique case (state_q)
            StIdle: begin
                if (chal_valid_i) begin
                    chal_d  = chal_data_i;
                    phase_d = '0;
                    eval_d  = '0;
                    ones_d  = '0;
                    state_d = StLow;
                end
            end
            StLow: begin
                if (phase_q == SetupLast) begin
                    phase_d = '0;
                    state_d = StHigh;
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end
            StHigh: begin
                if (phase_q == SettleLast) begin
                    phase_d = '0;
                    ones_d  = ones_sum;
                    eval_d  = eval_q + CNT_W'(1);
                    if (eval_q == EvalLast) begin
                        // Results are latched once here and held until the next DONE entry.
                        rbit_d    = (ones_sum > HalfRep);
                        rones_d   = ones_sum;
                        rstable_d = (ones_sum == '0) || (ones_sum == AllOnes);
                        state_d   = StDone;
                    end else begin
                        state_d = StLow;
                    end
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end
            StDone: begin
                if (resp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        excite_d = (state_d == StHigh);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            eval_q    <= '0;
            ones_q    <= '0;
            chal_q    <= '0;
            excite_q  <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            rbit_q    <= 1'b0;
            rones_q   <= '0;
            rstable_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            eval_q    <= eval_d;
            ones_q    <= ones_d;
            chal_q    <= chal_d;
            excite_q  <= excite_d;
            sync1_q   <= puf_response_i;
            sync2_q   <= sync1_q;
            rbit_q    <= rbit_d;
            rones_q   <= rones_d;
            rstable_q <= rstable_d;
        end
    end

    assign chal_ready_o    = (state_q == StIdle);
    assign busy_o          = (state_q != StIdle);
    assign resp_valid_o    = (state_q == StDone);
    assign puf_challenge_o = chal_q;
    assign puf_excite_l_o  = excite_q;
    assign puf_excite_r_o  = excite_q;
    assign resp_bit_o      = rbit_q;
    assign resp_ones_o     = rones_q;
    assign resp_stable_o   = rstable_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Randomized self-checking bench for puf_eval_ctrl against a firing-by-firing PUF model.
module tb_puf_eval_ctrl;

    localparam int CHAL_W = 40;
    localparam int SETUP  = 4;
    localparam int SETTLE = 8;
    localparam int REP    = 5;
    localparam int PERIOD = SETUP + SETTLE;
    localparam int LAT    = REP * PERIOD + 1;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              chal_valid_i = 1'b0;
    logic              chal_ready_o;
    logic [CHAL_W-1:0] chal_data_i = '0;
    logic [CHAL_W-1:0] puf_challenge_o;
    logic              puf_excite_l_o;
    logic              puf_excite_r_o;
    logic              puf_response_i = 1'b0;
    logic              resp_valid_o;
    logic              resp_ready_i = 1'b0;
    logic              resp_bit_o;
    logic [2:0]        resp_ones_o;
    logic              resp_stable_o;
    logic              busy_o;

    puf_eval_ctrl dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .chal_valid_i    (chal_valid_i),
        .chal_ready_o    (chal_ready_o),
        .chal_data_i     (chal_data_i),
        .puf_challenge_o (puf_challenge_o),
        .puf_excite_l_o  (puf_excite_l_o),
        .puf_excite_r_o  (puf_excite_r_o),
        .puf_response_i  (puf_response_i),
        .resp_valid_o    (resp_valid_o),
        .resp_ready_i    (resp_ready_i),
        .resp_bit_o      (resp_bit_o),
        .resp_ones_o     (resp_ones_o),
        .resp_stable_o   (resp_stable_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Per-firing PUF outcomes: bit k is the response of the k-th firing.
    logic [REP-1:0] puf_bits = '0;
    int fire   = 0;
    int hi_cnt = 0;

    // PUF model: response settles to the firing's value two cycles after excite rises.
    always @(posedge clk_i) begin
        #2;
        if (!busy_o) begin
            fire           = 0;
            hi_cnt         = 0;
            puf_response_i = 1'b0;
        end else if (puf_excite_l_o) begin
            hi_cnt++;
            puf_response_i = (hi_cnt >= 2 && fire < REP) ? puf_bits[fire] : 1'b0;
        end else begin
            if (hi_cnt > 0) fire++;
            hi_cnt         = 0;
            puf_response_i = 1'b0;
        end
    end

    logic [CHAL_W-1:0] exp_chal   = '0;
    logic              exp_bit    = 1'b0;
    logic [2:0]        exp_ones   = '0;
    logic              exp_stable = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_results();
        check_eq("resp_bit", resp_bit_o, exp_bit);
        check_eq("resp_ones", resp_ones_o, exp_ones);
        check_eq("resp_stable", resp_stable_o, exp_stable);
        check_eq("puf_challenge", puf_challenge_o, exp_chal);
    endtask

    // One challenge. abort_cyc > 0 pulses reset in that evaluation cycle instead of finishing.
    task automatic run_chal(input logic [CHAL_W-1:0] chal, input logic [REP-1:0] bits,
                            input int hold, input bit noisy, input int abort_cyc);
        int   t;
        int   ones;
        logic exp_ex;
        puf_bits = bits;
        resp_ready_i = 1'b0;
        @(negedge clk_i);
        t = 0;
        while (!chal_ready_o && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        check_eq("ready_timeout", chal_ready_o, 1'b1);
        chal_valid_i = 1'b1;
        chal_data_i  = chal;
        exp_chal     = chal;
        for (int c = 1; c < LAT; c++) begin
            @(negedge clk_i);
            exp_ex = ((c - 1) % PERIOD) >= SETUP;
            check_eq("excite_l", puf_excite_l_o, exp_ex);
            check_eq("excite_lr", puf_excite_r_o, puf_excite_l_o);
            check_eq("busy_eval", busy_o, 1'b1);
            check_eq("chal_ready_eval", chal_ready_o, 1'b0);
            check_eq("resp_valid_early", resp_valid_o, 1'b0);
            check_results();
            if (c == abort_cyc) begin
                chal_valid_i = 1'b0;
                #1 rst_ni = 1'b0;
                #1;
                check_eq("rst_excite_l", puf_excite_l_o, 1'b0);
                check_eq("rst_excite_r", puf_excite_r_o, 1'b0);
                check_eq("rst_busy", busy_o, 1'b0);
                check_eq("rst_resp_valid", resp_valid_o, 1'b0);
                exp_chal = '0; exp_bit = 1'b0; exp_ones = '0; exp_stable = 1'b0;
                check_results();
                @(negedge clk_i);
                rst_ni = 1'b1;
                return;
            end
            if (noisy) begin
                chal_valid_i = 1'b1;
                chal_data_i  = {$urandom, $urandom};
            end else begin
                chal_valid_i = 1'b0;
            end
        end
        @(negedge clk_i);
        chal_valid_i = 1'b0;
        ones       = $countones(bits);
        exp_ones   = 3'(ones);
        exp_bit    = (ones > REP / 2);
        exp_stable = (ones == 0) || (ones == REP);
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk_i);
            check_eq("resp_valid", resp_valid_o, 1'b1);
            check_eq("excite_done", puf_excite_l_o, 1'b0);
            check_eq("chal_ready_done", chal_ready_o, 1'b0);
            check_eq("busy_done", busy_o, 1'b1);
            check_results();
        end
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        resp_ready_i = 1'b0;
        check_eq("resp_valid_drop", resp_valid_o, 1'b0);
        check_eq("chal_ready_idle", chal_ready_o, 1'b1);
        check_eq("busy_idle", busy_o, 1'b0);
        check_results();
    endtask

    initial begin
        #1;
        check_eq("reset_busy", busy_o, 1'b0);
        check_eq("reset_valid", resp_valid_o, 1'b0);
        check_eq("reset_excite", puf_excite_l_o | puf_excite_r_o, 1'b0);
        check_eq("reset_ready", chal_ready_o, 1'b1);
        check_results();
        @(negedge clk_i);
        rst_ni = 1'b1;

        run_chal(40'hA55A5A5A5A, 5'b11111, 0, 1'b0, 0);
        run_chal({$urandom, $urandom}, 5'b00101, 20, 1'b1, 0);
        run_chal({$urandom, $urandom}, 5'b11111, 0, 1'b0, 2 * PERIOD + SETUP + 4);
        run_chal({$urandom, $urandom}, 5'b01000, 1, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            run_chal({$urandom, $urandom}, 5'($urandom), int'($urandom_range(0, 4)),
                     1'($urandom_range(0, 1)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
